pipeline_decode_hazard: RTL

PIPELINE_DECODE_HAZARD -- requirements
Module: pipeline_decode_hazard

---
 rtl/pipeline_pkg.sv | 83 ++++++++
 rtl/hazard_scoreboard.sv | 40 ++++
 rtl/pipeline_decode_hazard.sv | 79 +++++++
 3 files changed

// File: rtl/pipeline_pkg.sv
// Shared decode constants, latency table and instruction field decoder for the decode/hazard stage.
// HAZARD_MULDIV_EN: when defined, mul (SPECIAL2/funct 0x02) carries a two-cycle result latency.
package pipeline_pkg;

  localparam int REG_W = 5;
  localparam int N_W   = 2;
  localparam int CNT_W = 2;

  localparam logic [5:0] OP_SPECIAL  = 6'h00;
  localparam logic [5:0] OP_JAL      = 6'h03;
  localparam logic [5:0] OP_BEQ      = 6'h04;
  localparam logic [5:0] OP_BNE      = 6'h05;
  localparam logic [5:0] OP_IMM_LO   = 6'h08;
  localparam logic [5:0] OP_IMM_HI   = 6'h0F;
  localparam logic [5:0] OP_SPECIAL2 = 6'h1C;
  localparam logic [5:0] OP_LOAD_LO  = 6'h20;
  localparam logic [5:0] OP_LOAD_HI  = 6'h25;
  localparam logic [5:0] OP_STORE_LO = 6'h28;
  localparam logic [5:0] OP_MEM_HI   = 6'h2B;

  localparam logic [5:0] FN_SLL = 6'h00;
  localparam logic [5:0] FN_SRL = 6'h02;
  localparam logic [5:0] FN_SRA = 6'h03;
  localparam logic [5:0] FN_MUL = 6'h02;

  localparam logic [CNT_W-1:0] LAT_NONE = 2'd0;
  localparam logic [CNT_W-1:0] LAT_LOAD = 2'd1;
`ifdef HAZARD_MULDIV_EN
  localparam logic [CNT_W-1:0] LAT_MUL  = 2'd2;
`else
  localparam logic [CNT_W-1:0] LAT_MUL  = 2'd0;
`endif

  typedef struct packed {
    logic             rs_used;
    logic             rt_used;
    logic             dest_valid;
    logic [REG_W-1:0] rs;
    logic [REG_W-1:0] rt;
    logic [REG_W-1:0] dest;
    logic [CNT_W-1:0] lat;
  } dec_t;

  function automatic dec_t decode_inst(input logic [31:0] inst);
    dec_t       d;
    logic [5:0] op;
    logic [5:0] fn;
    logic       is_load;
    op      = inst[31:26];
    fn      = inst[5:0];
    is_load = (op >= OP_LOAD_LO) && (op <= OP_LOAD_HI);
    d       = '0;
    d.rs    = inst[25:21];
    d.rt    = inst[20:16];
    // shift-by-immediate forms leave the rs field unused
    d.rs_used = ((op == OP_SPECIAL) && !((fn == FN_SLL) || (fn == FN_SRL) || (fn == FN_SRA)))
             || ((op >= OP_BEQ) && (op <= OP_IMM_HI))
             || (op == OP_SPECIAL2)
             || ((op >= OP_LOAD_LO) && (op <= OP_MEM_HI));
    d.rt_used = (op == OP_SPECIAL) || (op == OP_BEQ) || (op == OP_BNE)
             || (op == OP_SPECIAL2)
             || ((op >= OP_STORE_LO) && (op <= OP_MEM_HI));
    if ((op == OP_SPECIAL) || (op == OP_SPECIAL2)) begin
      d.dest       = inst[15:11];
      d.dest_valid = 1'b1;
    end else if (((op >= OP_IMM_LO) && (op <= OP_IMM_HI)) || is_load) begin
      d.dest       = inst[20:16];
      d.dest_valid = 1'b1;
    end else if (op == OP_JAL) begin
      d.dest       = 5'd31;
      d.dest_valid = 1'b1;
    end
    if (is_load) begin
      d.lat = LAT_LOAD;
    end else if ((op == OP_SPECIAL2) && (fn == FN_MUL)) begin
      d.lat = LAT_MUL;
    end else begin
      d.lat = LAT_NONE;
    end
    return d;
  endfunction

endpackage

// File: rtl/hazard_scoreboard.sv
// Per-register result-pending counters: two read ports, one set port, all nonzero counts decrement each cycle.
// Register 0 is hardwired to zero so it never reports a hazard.
module hazard_scoreboard import pipeline_pkg::*; (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] raddr_a,
  input  logic [REG_W-1:0] raddr_b,
  output logic [CNT_W-1:0] rdata_a,
  output logic [CNT_W-1:0] rdata_b,
  input  logic             set_en,
  input  logic [REG_W-1:0] set_addr,
  input  logic [CNT_W-1:0] set_val
);

  logic [CNT_W-1:0] cnt [32];

  always_ff @(posedge clk) begin
    cnt[0] <= '0;
    if (rst) begin
      for (int i = 1; i < 32; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      // a new producer overrides the countdown of the previous one
      for (int i = 1; i < 32; i++) begin
        if (set_en && (set_addr == REG_W'(i))) begin
          cnt[i] <= set_val;
        end else if (cnt[i] != '0) begin
          cnt[i] <= cnt[i] - 1'b1;
        end
      end
    end
  end

  always_comb begin
    rdata_a = (raddr_a == '0) ? '0 : cnt[raddr_a];
    rdata_b = (raddr_b == '0) ? '0 : cnt[raddr_b];
  end

endmodule

// File: rtl/pipeline_decode_hazard.sv
// Decode stage with scoreboard-based load/mul-use hazard detection and fetch stall requests.
// HAZARD_MULDIV_EN (see pipeline_pkg) enables the two-cycle mul latency.
module pipeline_decode_hazard import pipeline_pkg::*; #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       inst_in,
  input  logic [DATA_W-1:0] pc_in,
  input  logic              flush,
  output logic [N_W-1:0]    stall_request,
  output logic [31:0]       inst_out,
  output logic [DATA_W-1:0] pc_out,
  output logic              issue_valid
);

  logic [31:0]       dinst;
  logic [DATA_W-1:0] dpc;
  logic [N_W-1:0]    stall_cnt;
  logic [N_W-1:0]    need;
  logic [CNT_W-1:0]  cnt_rs;
  logic [CNT_W-1:0]  cnt_rt;
  logic [CNT_W-1:0]  wait_rs;
  logic [CNT_W-1:0]  wait_rt;
  logic              req;
  logic              issue;
  logic              set_en;
  dec_t              dec;

  hazard_scoreboard u_sb (
    .clk      (clk),
    .rst      (rst),
    .raddr_a  (dec.rs),
    .raddr_b  (dec.rt),
    .rdata_a  (cnt_rs),
    .rdata_b  (cnt_rt),
    .set_en   (set_en),
    .set_addr (dec.dest),
    .set_val  (dec.lat)
  );

  // hazard evaluation looks only at the decode register, never at inst_in
  always_comb begin
    dec     = decode_inst(dinst);
    wait_rs = dec.rs_used ? cnt_rs : '0;
    wait_rt = dec.rt_used ? cnt_rt : '0;
    need    = N_W'((wait_rs > wait_rt) ? wait_rs : wait_rt);
    req     = !rst && !flush && (stall_cnt == '0) && (need != '0);
    issue   = !rst && !flush && (stall_cnt == '0) && (need == '0) && (dinst != '0);
    set_en  = issue && dec.dest_valid && (dec.lat != LAT_NONE);
  end

  always_comb begin
    stall_request = req ? need : '0;
    inst_out      = issue ? dinst : '0;
    issue_valid   = issue;
    pc_out        = rst ? '0 : dpc;
  end

  // decode register stage: flush beats request, request and countdown hold the instruction
  always_ff @(posedge clk) begin
    if (rst) begin
      dinst     <= '0;
      dpc       <= '0;
      stall_cnt <= '0;
    end else if (flush) begin
      dinst     <= '0;
      stall_cnt <= '0;
    end else if (req) begin
      stall_cnt <= need - 1'b1;
    end else if (stall_cnt != '0) begin
      stall_cnt <= stall_cnt - 1'b1;
    end else begin
      dinst <= inst_in;
      dpc   <= pc_in;
    end
  end

endmodule
